data_access_unit: RTL and testbench
===================================

Name: data_access_unit

Overview:
- Data-memory access controller in the M stage; produces BusyDA, which the hazard unit consumes.
- Turns a scalar (32-bit) or vector (128-bit) load/store into one or more 32-bit req/ack beats on the data-memory port.
- Holds BusyDA high so the whole pipeline stalls until the access completes.
- Assembles vector read data and presents it for exactly one non-busy cycle.

Parameters:
DATA_W, 32, memory word / scalar width
VEC_W, 128, vector register width; VEC_W/DATA_W = beats per vector access (NB = 4)
ADDR_W, 32, byte address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
MemReadM  in  1  load in M stage
MemWriteM  in  1  store in M stage
VecM  in  1  1 = vector access, 0 = scalar
ALUResultM  in  ADDR_W  byte address
WriteDataM  in  DATA_W  scalar store data
WriteDataVM  in  VEC_W  vector store data
ReadDataM  out  DATA_W  scalar load result (registered)
ReadDataVM  out  VEC_W  vector load result (registered)
BusyDA  out  1  stall request to hazard unit
mem_req  out  1  beat request, held until mem_ack
mem_we  out  1  1 = write beat
mem_addr  out  ADDR_W  beat byte address
mem_wdata  out  DATA_W  beat write data
mem_rdata  in  DATA_W  beat read data, valid with mem_ack
mem_ack  in  1  beat complete; may arrive in the same cycle as mem_req

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values:
  - state = IDLE; beat counter = 0.
  - BusyDA, mem_req, mem_we = 0; mem_addr, mem_wdata = 0.
  - ReadDataM, ReadDataVM = 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - start = MemReadM | MemWriteM.
  - If start: BusyDA = 1 combinationally in the same cycle; latch base, we (MemWriteM), vec, store data; beat = 0; next = ACCESS.
  - MemReadM and MemWriteM both high: treated as a write.
- ACCESS:
  - BusyDA = 1; mem_req = 1.
  - mem_we = latched we; addr/data of the current beat are stable while mem_req is high.
  - On mem_ack with a read: capture mem_rdata into slot[beat].
  - On the last-beat ack: next = DONE. Otherwise beat += 1.
  - Last beat: beat == 0 for scalar, beat == NB-1 for vector.
- DONE:
  - BusyDA = 0; mem_req = 0.
  - ReadDataM / ReadDataVM hold the new data; the pipeline advances this cycle.
  - next = IDLE unconditionally. A request still visible in DONE belongs to the completing instruction and is ignored.
- Addressing:
  - Scalar: mem_addr = base.
  - Vector: base low log2(VEC_W/8) bits are forced to 0; mem_addr = base + beat*(DATA_W/8).
  - Wrap-around of the address is modulo 2^ADDR_W.
- Lane order (little-endian): beat i carries bits [i*DATA_W +: DATA_W] of WriteDataVM / ReadDataVM.
- Read results:
  - Scalar read updates ReadDataM only; vector read updates ReadDataVM only.
  - Writes update neither.
  - Outputs hold their value until the next read of the same kind.
- Timing (zero-wait ack):
  - Scalar: BusyDA high 2 cycles, DONE on cycle 3.
  - Vector: BusyDA high 1+NB = 5 cycles, then DONE.
  - Each wait cycle on mem_ack adds one cycle.
- Robustness:
  - mem_ack while mem_req = 0 is ignored.
  - Inputs changing during ACCESS are ignored; all values are latched in IDLE.
- rst mid-access: next cycle state = IDLE, mem_req = 0, BusyDA = 0, read outputs = 0. A pending memory ack is ignored.
- Back-to-back: a new request is detected in the first IDLE cycle after DONE. Minimum one non-busy cycle between accesses.

Test Plan:
- Scalar load, addr 0x100, immediate ack, mem_rdata = 0xDEADBEEF -> BusyDA = 1 for 2 cycles; mem_addr = 0x100, mem_we = 0; in DONE, ReadDataM = 0xDEADBEEF and BusyDA = 0.
- Vector store, addr 0x20C, WriteDataVM = 0x44444444_33333333_22222222_11111111, ack delayed 2 cycles per beat:
  - mem_addr = 0x200, 0x204, 0x208, 0x20C with wdata 0x11111111..0x44444444.
  - mem_req held through waits; BusyDA high 1+4*3 = 13 cycles.
- Vector load, addr 0x40, rdata words A0,A1,A2,A3 -> ReadDataVM = {A3,A2,A1,A0}; ReadDataM unchanged.
- Back-to-back scalar store then scalar load -> BusyDA sequence 1,1,0,1,1,0; second access uses the new address; the request in the DONE cycle does not re-trigger.
- rst asserted during beat 2 of a vector load -> next cycle IDLE, BusyDA = 0, mem_req = 0, ReadDataVM = 0; a later ack pulse has no effect.
- Spurious mem_ack in IDLE, plus MemReadM = MemWriteM = 1 -> no capture in IDLE; the dual request issues write beats (mem_we = 1).

Source files
------------

// File: rtl/data_access_unit.sv
// data_access_unit: M-stage data-memory access controller.
// Splits scalar/vector loads and stores into DATA_W req/ack beats and stalls the pipeline through BusyDA.
module data_access_unit #(
   parameter int DATA_W = 32,
   parameter int VEC_W  = 128,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemReadM,
   input  logic              MemWriteM,
   input  logic              VecM,
   input  logic [ADDR_W-1:0] ALUResultM,
   input  logic [DATA_W-1:0] WriteDataM,
   input  logic [VEC_W-1:0]  WriteDataVM,
   output logic [DATA_W-1:0] ReadDataM,
   output logic [VEC_W-1:0]  ReadDataVM,
   output logic              BusyDA,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);
   localparam int NB     = VEC_W / DATA_W;
   localparam int BEAT_W = (NB > 1) ? $clog2(NB) : 1;
   localparam int ALIGN  = $clog2(VEC_W / 8);
   localparam int BYTES  = DATA_W / 8;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic                we_q, we_d;
   logic                vec_q, vec_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [VEC_W-1:0]    wdata_v_q, wdata_v_d;
   logic [VEC_W-1:0]    slot_q, slot_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [VEC_W-1:0]    rdata_v_q, rdata_v_d;
   logic                start_s;
   logic                last_s;
   logic [ADDR_W-1:0]   vec_base_s;

   assign start_s    = MemReadM | MemWriteM;
   assign last_s     = vec_q ? (beat_q == BEAT_W'(NB - 1)) : (beat_q == {BEAT_W{1'b0}});
   assign vec_base_s = base_q & ~((ADDR_W'(1) << ALIGN) - ADDR_W'(1));

   // Beat address/data come only from latched state so they stay stable while mem_req waits for ack.
   assign BusyDA    = (state_q == S_ACCESS) | ((state_q == S_IDLE) & start_s);
   assign mem_req   = (state_q == S_ACCESS);
   assign mem_we    = mem_req & we_q;
   assign mem_addr  = vec_q ? (vec_base_s + (ADDR_W'(beat_q) * ADDR_W'(BYTES))) : base_q;
   assign mem_wdata = vec_q ? wdata_v_q[int'(beat_q) * DATA_W +: DATA_W] : wdata_q;
   assign ReadDataM  = rdata_q;
   assign ReadDataVM = rdata_v_q;

   // Next-state logic: request latch, beat sequencing and read-lane assembly.
   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      base_d    = base_q;
      we_d      = we_q;
      vec_d     = vec_q;
      wdata_d   = wdata_q;
      wdata_v_d = wdata_v_q;
      slot_d    = slot_q;
      rdata_d   = rdata_q;
      rdata_v_d = rdata_v_q;
      case (state_q)
         S_IDLE: begin
            if (start_s) begin
               base_d    = ALUResultM;
               we_d      = MemWriteM;
               vec_d     = VecM;
               wdata_d   = WriteDataM;
               wdata_v_d = WriteDataVM;
               beat_d    = {BEAT_W{1'b0}};
               state_d   = S_ACCESS;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_ACCESS: begin
            if (mem_ack) begin
               if (!we_q) begin
                  slot_d[int'(beat_q) * DATA_W +: DATA_W] = mem_rdata;
               end else begin
                  slot_d = slot_q;
               end
               // Results become visible only once the final beat lands, never partially.
               if (last_s) begin
                  state_d = S_DONE;
                  if (we_q) begin
                     rdata_d = rdata_q;
                  end else if (vec_q) begin
                     rdata_v_d = slot_d;
                  end else begin
                     rdata_d = mem_rdata;
                  end
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end else begin
               state_d = S_ACCESS;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         beat_q    <= {BEAT_W{1'b0}};
         base_q    <= {ADDR_W{1'b0}};
         we_q      <= 1'b0;
         vec_q     <= 1'b0;
         wdata_q   <= {DATA_W{1'b0}};
         wdata_v_q <= {VEC_W{1'b0}};
         slot_q    <= {VEC_W{1'b0}};
         rdata_q   <= {DATA_W{1'b0}};
         rdata_v_q <= {VEC_W{1'b0}};
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         base_q    <= base_d;
         we_q      <= we_d;
         vec_q     <= vec_d;
         wdata_q   <= wdata_d;
         wdata_v_q <= wdata_v_d;
         slot_q    <= slot_d;
         rdata_q   <= rdata_d;
         rdata_v_q <= rdata_v_d;
      end
   end
endmodule

// File: tb/tb_data_access_unit.sv
// tb_data_access_unit: randomized and directed bench for data_access_unit.
// A bench-side memory answers beats; a transaction-level model predicts beats, stall length and read results.
module tb_data_access_unit;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         MemReadM = 1'b0, MemWriteM = 1'b0, VecM = 1'b0;
   logic [31:0]  ALUResultM = 32'd0, WriteDataM = 32'd0;
   logic [127:0] WriteDataVM = 128'd0;
   logic [31:0]  ReadDataM;
   logic [127:0] ReadDataVM;
   logic         BusyDA, mem_req, mem_we;
   logic [31:0]  mem_addr, mem_wdata;
   wire  [31:0]  mem_rdata;
   wire          mem_ack;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] mem_model [logic [31:0]];
   int          ack_delay = 0;
   int          wait_cnt  = 0;
   int          stab_err  = 0;
   logic        resp_ack  = 1'b0;
   logic [31:0] resp_rdata = 32'd0;
   logic        man_ack   = 1'b0;
   logic [31:0] man_rdata = 32'd0;
   logic [31:0] beat_addr0 = 32'd0;
   logic [31:0] log_addr[$];
   logic [31:0] log_wdata[$];
   logic        log_we[$];

   logic [31:0]  ref_rd_s = 32'd0;
   logic [127:0] ref_rd_v = 128'd0;
   logic [31:0]  exp_addr[$];
   logic [31:0]  exp_wdata[$];
   logic         exp_we[$];
   int           exp_busy;

   assign mem_ack   = resp_ack | man_ack;
   assign mem_rdata = man_ack ? man_rdata : resp_rdata;

   data_access_unit dut (
      .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .VecM(VecM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WriteDataVM(WriteDataVM),
      .ReadDataM(ReadDataM), .ReadDataVM(ReadDataVM), .BusyDA(BusyDA),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
   endfunction

   // Memory responder: acks each beat after ack_delay wait cycles and logs the completed beat.
   always @(negedge clk) begin
      if (mem_req === 1'b1 && rst === 1'b0) begin
         if (wait_cnt == 0) beat_addr0 = mem_addr;
         else if (mem_addr !== beat_addr0) stab_err++;
         if (wait_cnt >= ack_delay) begin
            resp_ack   = 1'b1;
            resp_rdata = mem_val(mem_addr);
            log_addr.push_back(mem_addr);
            log_we.push_back(mem_we);
            log_wdata.push_back(mem_wdata);
            if (mem_we) mem_model[mem_addr] = mem_wdata;
            wait_cnt = 0;
         end else begin
            resp_ack   = 1'b0;
            resp_rdata = $urandom;
            wait_cnt++;
         end
      end else begin
         resp_ack = 1'b0;
         wait_cnt = 0;
      end
   end

   // Transaction model: beat list, stall length and updated read results from the access rules.
   task automatic model_access(input bit wr, input bit vec, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic [127:0] vdata, input int delay);
      int nb;
      logic [31:0] a;
      nb = vec ? 4 : 1;
      exp_addr.delete(); exp_we.delete(); exp_wdata.delete();
      exp_busy = 1 + nb * (delay + 1);
      for (int i = 0; i < nb; i++) begin
         a = vec ? ((addr & 32'hFFFF_FFF0) + 32'(4 * i)) : addr;
         exp_addr.push_back(a);
         exp_we.push_back(wr);
         exp_wdata.push_back(vec ? vdata[32 * i +: 32] : sdata);
         if (!wr) begin
            if (vec) ref_rd_v[32 * i +: 32] = mem_val(a);
            else     ref_rd_s = mem_val(a);
         end
      end
   endtask

   // Issues one access and returns in its DONE cycle; request and scrambled inputs stay visible meanwhile.
   task automatic do_access(input bit rd, input bit wr, input bit vec, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [127:0] vdata, input int delay,
                            output int busy);
      @(negedge clk);
      ack_delay = delay;
      log_addr.delete(); log_we.delete(); log_wdata.delete();
      MemReadM = rd; MemWriteM = wr; VecM = vec;
      ALUResultM = addr; WriteDataM = sdata; WriteDataVM = vdata;
      #1;
      busy = 0;
      while (BusyDA === 1'b1 && busy < 200) begin
         busy++;
         @(negedge clk);
         ALUResultM  = $urandom;
         WriteDataM  = $urandom;
         WriteDataVM = {$urandom, $urandom, $urandom, $urandom};
         VecM        = 1'($urandom_range(0, 1));
         #1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         MemReadM = 1'b0; MemWriteM = 1'b0;
         #1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (BusyDA !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0) $display("FAIL reset_ctl busy=%b req=%b we=%b required 0 0 0", BusyDA, mem_req, mem_we);
      else n_pass++;
      n_checks++;
      if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) $display("FAIL reset_bus addr=%h wdata=%h required 0 0", mem_addr, mem_wdata);
      else n_pass++;
      n_checks++;
      if (ReadDataM !== 32'd0 || ReadDataVM !== 128'd0) $display("FAIL reset_rd s=%h v=%h required 0 0", ReadDataM, ReadDataVM);
      else n_pass++;
      rst = 1'b0;
      ref_rd_s = 32'd0; ref_rd_v = 128'd0;
      idle(1);
   endtask

   task automatic test_scalar_load;
      int busy;
      mem_model[32'h100] = 32'hDEADBEEF;
      do_access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 128'h0, 0, busy);
      n_checks++;
      if (busy !== 2) $display("FAIL sload_busy got=%0d required=2", busy); else n_pass++;
      n_checks++;
      if (log_addr.size() != 1 || log_addr[0] !== 32'h100 || log_we[0] !== 1'b0)
         $display("FAIL sload_beat beats=%0d required 1 beat addr=100 we=0", log_addr.size());
      else n_pass++;
      n_checks++;
      if (ReadDataM !== 32'hDEADBEEF || mem_req !== 1'b0) $display("FAIL sload_done rd=%h req=%b required deadbeef 0", ReadDataM, mem_req);
      else n_pass++;
      ref_rd_s = 32'hDEADBEEF;
      idle(2);
   endtask

   task automatic test_vector_store;
      int busy;
      logic [127:0] vd;
      vd = 128'h44444444_33333333_22222222_11111111;
      stab_err = 0;
      do_access(1'b0, 1'b1, 1'b1, 32'h20C, 32'h0, vd, 2, busy);
      n_checks++;
      if (busy !== 13) $display("FAIL vstore_busy got=%0d required=13", busy); else n_pass++;
      n_checks++;
      if (log_addr.size() != 4) $display("FAIL vstore_nbeats got=%0d required=4", log_addr.size());
      else n_pass++;
      for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
         n_checks++;
         if (log_addr[i] !== 32'h200 + 32'(4 * i) || log_wdata[i] !== 32'h11111111 * 32'(i + 1) || log_we[i] !== 1'b1)
            $display("FAIL vstore_beat%0d addr=%h wdata=%h we=%b required %h %h 1", i, log_addr[i], log_wdata[i], log_we[i],
                     32'h200 + 32'(4 * i), 32'h11111111 * 32'(i + 1));
         else n_pass++;
      end
      n_checks++;
      if (stab_err != 0 || ReadDataVM !== ref_rd_v || ReadDataM !== ref_rd_s)
         $display("FAIL vstore_side stab_err=%0d rdv=%h rds=%h required 0 %h %h", stab_err, ReadDataVM, ReadDataM, ref_rd_v, ref_rd_s);
      else n_pass++;
      idle(1);
   endtask

   task automatic test_vector_load;
      int busy;
      logic [31:0] w [4];
      for (int i = 0; i < 4; i++) begin
         w[i] = $urandom;
         mem_model[32'h40 + 32'(4 * i)] = w[i];
      end
      do_access(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 128'h0, 1, busy);
      n_checks++;
      if (busy !== 9) $display("FAIL vload_busy got=%0d required=9", busy); else n_pass++;
      n_checks++;
      if (ReadDataVM !== {w[3], w[2], w[1], w[0]}) $display("FAIL vload_data got=%h required=%h", ReadDataVM, {w[3], w[2], w[1], w[0]});
      else n_pass++;
      n_checks++;
      if (ReadDataM !== ref_rd_s) $display("FAIL vload_scalar_kept got=%h required=%h", ReadDataM, ref_rd_s); else n_pass++;
      ref_rd_v = {w[3], w[2], w[1], w[0]};
      idle(1);
   endtask

   task automatic test_back_to_back;
      int b1, b2;
      logic [31:0] d;
      d = $urandom;
      mem_model[32'h3000] = 32'hCAFE_0001;
      do_access(1'b0, 1'b1, 1'b0, 32'h2000, d, 128'h0, 0, b1);
      do_access(1'b1, 1'b0, 1'b0, 32'h3000, 32'h0, 128'h0, 0, b2);
      n_checks++;
      if (b1 !== 2 || b2 !== 2) $display("FAIL b2b_busy got=%0d,%0d required 2,2", b1, b2); else n_pass++;
      n_checks++;
      if (log_addr.size() != 1 || log_addr[0] !== 32'h3000 || log_we[0] !== 1'b0)
         $display("FAIL b2b_second_beat beats=%0d required 1 beat addr=3000 we=0", log_addr.size());
      else n_pass++;
      n_checks++;
      if (mem_model[32'h2000] !== d || ReadDataM !== 32'hCAFE_0001)
         $display("FAIL b2b_data mem=%h rd=%h required %h cafe0001", mem_model[32'h2000], ReadDataM, d);
      else n_pass++;
      ref_rd_s = 32'hCAFE_0001;
      idle(1);
      n_checks++;
      if (BusyDA !== 1'b0 || mem_req !== 1'b0) $display("FAIL b2b_no_retrigger busy=%b req=%b required 0 0", BusyDA, mem_req);
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      int t;
      @(negedge clk);
      ack_delay = 1;
      log_addr.delete(); log_we.delete(); log_wdata.delete();
      MemReadM = 1'b1; MemWriteM = 1'b0; VecM = 1'b1; ALUResultM = 32'h80;
      t = 0;
      #1;
      while (log_addr.size() < 2 && t < 50) begin
         @(negedge clk); #1; t++;
      end
      n_checks++;
      if (t >= 50) $display("FAIL rstmid_reach_beat2 beats=%0d required 2", log_addr.size()); else n_pass++;
      @(negedge clk);
      rst = 1'b1; MemReadM = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if (BusyDA !== 1'b0 || mem_req !== 1'b0 || ReadDataVM !== 128'd0 || ReadDataM !== 32'd0)
         $display("FAIL rstmid_state busy=%b req=%b rdv=%h rds=%h required 0 0 0 0", BusyDA, mem_req, ReadDataVM, ReadDataM);
      else n_pass++;
      rst = 1'b0;
      ref_rd_s = 32'd0; ref_rd_v = 128'd0;
      @(negedge clk);
      man_rdata = 32'h1357_9BDF; man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      #1;
      n_checks++;
      if (BusyDA !== 1'b0 || mem_req !== 1'b0 || ReadDataVM !== 128'd0 || ReadDataM !== 32'd0)
         $display("FAIL rstmid_late_ack busy=%b req=%b rdv=%h rds=%h required 0 0 0 0", BusyDA, mem_req, ReadDataVM, ReadDataM);
      else n_pass++;
   endtask

   task automatic test_dual_spurious;
      int busy;
      logic [31:0] d;
      d = $urandom;
      idle(1);
      @(negedge clk);
      man_rdata = 32'hBAD0_BAD0; man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      #1;
      n_checks++;
      if (ReadDataM !== ref_rd_s || BusyDA !== 1'b0) $display("FAIL spurious_ack rd=%h busy=%b required %h 0", ReadDataM, BusyDA, ref_rd_s);
      else n_pass++;
      do_access(1'b1, 1'b1, 1'b0, 32'h500, d, 128'h0, 0, busy);
      n_checks++;
      if (log_addr.size() != 1 || log_we[0] !== 1'b1 || log_wdata[0] !== d)
         $display("FAIL dual_is_write beats=%0d required 1 write beat of %h", log_addr.size(), d);
      else n_pass++;
      n_checks++;
      if (ReadDataM !== ref_rd_s || busy !== 2) $display("FAIL dual_side rd=%h busy=%0d required %h 2", ReadDataM, busy, ref_rd_s);
      else n_pass++;
      idle(1);
   endtask

   task automatic test_random;
      int busy, delay;
      bit wr, rd, vec, ok;
      logic [31:0] addr, sd;
      logic [127:0] vd;
      for (int n = 0; n < 25; n++) begin
         wr = 1'($urandom_range(0, 1));
         rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         vec = 1'($urandom_range(0, 1));
         addr = $urandom;
         sd = $urandom;
         vd = {$urandom, $urandom, $urandom, $urandom};
         delay = $urandom_range(0, 2);
         model_access(wr, vec, addr, sd, vd, delay);
         do_access(rd, wr, vec, addr, sd, vd, delay, busy);
         n_checks++;
         if (busy !== exp_busy) $display("FAIL rand%0d_busy got=%0d required=%0d", n, busy, exp_busy); else n_pass++;
         ok = (log_addr.size() == exp_addr.size());
         for (int i = 0; ok && i < exp_addr.size(); i++)
            if (log_addr[i] !== exp_addr[i] || log_we[i] !== exp_we[i] || (exp_we[i] && log_wdata[i] !== exp_wdata[i])) ok = 1'b0;
         n_checks++;
         if (!ok) $display("FAIL rand%0d_beats got %0d beats first addr=%h required %0d beats first addr=%h", n,
                           log_addr.size(), (log_addr.size() > 0) ? log_addr[0] : 32'd0, exp_addr.size(), exp_addr[0]);
         else n_pass++;
         n_checks++;
         if (ReadDataM !== ref_rd_s || ReadDataVM !== ref_rd_v)
            $display("FAIL rand%0d_rd s=%h v=%h required %h %h", n, ReadDataM, ReadDataVM, ref_rd_s, ref_rd_v);
         else n_pass++;
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      end
      idle(1);
   endtask

   initial begin
      test_reset();
      test_scalar_load();
      test_vector_store();
      test_vector_load();
      test_back_to_back();
      test_reset_mid();
      test_dual_spurious();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
